// File: rtl/tap_sequencer.sv
// tap_sequencer: command-driven JTAG master for tap_controller.
// It turns RESET / IR_SCAN / DR_SCAN / IDLE commands into registered TMS/TDI
// sequences and collects TDO during shift. It also keeps a mirror of the TAP
// state that is updated on every edge with the same next-state function.
//
// Ports
//   TCLK, TRST         clock, synchronous active-high reset (shared with TAP)
//   cmd_valid/ready    command handshake; ready only while idle
//   cmd_op             0 RESET, 1 IR_SCAN, 2 DR_SCAN, 3 IDLE
//   cmd_len            scan bits - 1, or idle cycles - 1
//   cmd_data           TDI bits, LSB shifted first
//   TMS, TDI           registered outputs to the TAP
//   TDO                serial data from the scan chain
//   rsp_valid          one-cycle completion pulse
//   rsp_data           captured TDO, bit i = i-th shifted bit
//   STATE_MIR          mirrored TAP state (0 Test_logic_reset .. 15 Update_IR)
//
// Build option: define TAP_SEQ_TDO_CAPTURE_EN to build the TDO capture
// register. Without it rsp_data is tied to 0 and TDO is ignored.
module tap_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN)
) (
    input  logic               TCLK,
    input  logic               TRST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic [3:0]         STATE_MIR
);
    // The counter also walks the 6-bit RESET head, so it needs at least 3 bits.
    localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_IDLE  = 2'd3;
    localparam logic [3:0] TAP_TLR  = 4'd0;
    localparam logic [3:0] TAP_RTI  = 4'd1;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HEAD, S_SHIFT, S_TAIL, S_DONE} state_t;

    state_t             r_state, w_state_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n, w_head_last, w_len_ext;
    logic [1:0]         r_op, w_op;
    logic [LEN_W-1:0]   r_len, w_len, w_len_c;
    logic [MAX_LEN-1:0] r_data, w_data;
    logic               r_tms, r_tdi, w_tms_n, w_tdi_n, w_accept;
    logic [3:0]         r_mir, w_mir_n;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
        logic [3:0] n;
        n = TAP_TLR;
        case (s)
            4'd0:  n = tms ? 4'd0  : 4'd1;
            4'd1:  n = tms ? 4'd2  : 4'd1;
            4'd2:  n = tms ? 4'd9  : 4'd3;
            4'd3:  n = tms ? 4'd5  : 4'd4;
            4'd4:  n = tms ? 4'd5  : 4'd4;
            4'd5:  n = tms ? 4'd8  : 4'd6;
            4'd6:  n = tms ? 4'd7  : 4'd6;
            4'd7:  n = tms ? 4'd8  : 4'd4;
            4'd8:  n = tms ? 4'd2  : 4'd1;
            4'd9:  n = tms ? 4'd0  : 4'd10;
            4'd10: n = tms ? 4'd12 : 4'd11;
            4'd11: n = tms ? 4'd12 : 4'd11;
            4'd12: n = tms ? 4'd15 : 4'd13;
            4'd13: n = tms ? 4'd14 : 4'd13;
            4'd14: n = tms ? 4'd15 : 4'd11;
            4'd15: n = tms ? 4'd2  : 4'd1;
        endcase
        return n;
    endfunction

    // Clamp only exists when cmd_len can encode values >= MAX_LEN.
    if ((1 << LEN_W) > MAX_LEN) begin : g_clamp
        localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN - 1);
        assign w_len_c = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    end else begin : g_noclamp
        assign w_len_c = cmd_len;
    end

    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    // On the accept edge the first TMS bit is derived from the incoming command.
    assign w_op      = w_accept ? cmd_op   : r_op;
    assign w_len     = w_accept ? w_len_c  : r_len;
    assign w_data    = w_accept ? cmd_data : r_data;
    assign w_len_ext = CNT_W'(w_len);
    assign w_mir_n   = tap_next(r_mir, r_tms);

    always_comb begin
        w_head_last = CNT_W'(2);
        if (w_op == OP_RESET)   w_head_last = CNT_W'(5);
        else if (w_op == OP_IR) w_head_last = CNT_W'(3);
    end

    always_ff @(posedge TCLK) begin
        if (TRST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_RESET;
            r_len   <= '0;
            r_data  <= '0;
            r_tms   <= 1'b1;
            r_tdi   <= 1'b0;
            r_mir   <= TAP_TLR;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_tms   <= w_tms_n;
            r_tdi   <= w_tdi_n;
            r_mir   <= w_mir_n;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_len  <= w_len_c;
                r_data <= cmd_data;
            end
        end
    end

    // Next phase/index, then the TMS/TDI bit that belongs to that phase/index.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_tms_n   = 1'b1;
        w_tdi_n   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_cnt_n = '0;
                    if (r_mir == TAP_TLR && cmd_op != OP_RESET) w_state_n = S_PRE;
                    else if (cmd_op == OP_IDLE)                 w_state_n = S_SHIFT;
                    else                                        w_state_n = S_HEAD;
                end
            end
            S_PRE: begin
                w_cnt_n   = '0;
                w_state_n = (r_op == OP_IDLE) ? S_SHIFT : S_HEAD;
            end
            S_HEAD: begin
                if (r_cnt == w_head_last) begin
                    w_cnt_n   = '0;
                    w_state_n = (r_op == OP_RESET) ? S_DONE : S_SHIFT;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (r_cnt == w_len_ext) begin
                    w_cnt_n   = '0;
                    w_state_n = (r_op == OP_IDLE) ? S_DONE : S_TAIL;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_TAIL: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_cnt_n   = '0;
                    w_state_n = S_DONE;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase

        case (w_state_n)
            S_PRE:   w_tms_n = 1'b0;
            S_HEAD: begin
                if (w_op == OP_RESET)   w_tms_n = (w_cnt_n < CNT_W'(5));
                else if (w_op == OP_IR) w_tms_n = (w_cnt_n < CNT_W'(2));
                else                    w_tms_n = (w_cnt_n == '0);
            end
            S_SHIFT: begin
                if (w_op != OP_IDLE) begin
                    w_tms_n = (w_cnt_n == w_len_ext);
                    w_tdi_n = w_data[w_cnt_n[LEN_W-1:0]];
                end else begin
                    w_tms_n = 1'b0;
                end
            end
            S_TAIL:  w_tms_n = (w_cnt_n == '0);
            // Idle/done: park the TAP where it will be after this edge.
            default: w_tms_n = (w_mir_n != TAP_RTI);
        endcase
    end

`ifdef TAP_SEQ_TDO_CAPTURE_EN
    logic [MAX_LEN-1:0] r_rsp;

    // The TAP sits in Shift_xR on every edge that consumes a SHIFT bit.
    always_ff @(posedge TCLK) begin
        if (TRST || w_accept)
            r_rsp <= '0;
        else if (r_state == S_SHIFT && r_op != OP_IDLE)
            r_rsp[r_cnt[LEN_W-1:0]] <= TDO;
    end

    assign rsp_data = r_rsp;
`else
    logic w_unused_tdo;
    assign w_unused_tdo = TDO;
    assign rsp_data     = '0;
`endif

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign TMS       = r_tms;
    assign TDI       = r_tdi;
    assign STATE_MIR = r_mir;
endmodule

// File: tb/tb_tap_sequencer.sv
// Directed + random bench for tap_sequencer. A TAP reference model follows the
// DUT's TMS and must agree with STATE_MIR after every edge.
module tb_tap_sequencer;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 5;
`ifdef TAP_SEQ_TDO_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    // TAP next state for TMS = 0 / TMS = 1.
    localparam logic [3:0] T0 [16] = '{4'd1, 4'd1, 4'd3, 4'd4, 4'd4, 4'd6, 4'd6, 4'd4,
                                       4'd1, 4'd10, 4'd11, 4'd11, 4'd13, 4'd13, 4'd11, 4'd1};
    localparam logic [3:0] T1 [16] = '{4'd0, 4'd2, 4'd9, 4'd5, 4'd5, 4'd8, 4'd7, 4'd8,
                                       4'd2, 4'd0, 4'd12, 4'd12, 4'd15, 4'd14, 4'd15, 4'd2};

    logic               TCLK = 1'b0;
    logic               TRST = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'd0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               TMS, TDI, TDO;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic [3:0]         STATE_MIR;

    logic       tdo_loop = 1'b1;
    logic       tdo_val  = 1'b0;
    logic [3:0] tap_m    = 4'd0;
    int         n_vec    = 0;
    int         n_err    = 0;

    assign TDO = tdo_loop ? TDI : tdo_val;

    always #5 TCLK = ~TCLK;

    tap_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .TCLK(TCLK), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .TMS(TMS), .TDI(TDI), .TDO(TDO), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .STATE_MIR(STATE_MIR)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge; the model consumes the TMS the DUT is presenting.
    task automatic step();
        tap_m = TRST ? 4'd0 : (TMS ? T1[tap_m] : T0[tap_m]);
        @(posedge TCLK);
        #1;
        chk("mir", 64'(STATE_MIR), 64'(tap_m));
    endtask

    function automatic int seq_len(input logic [1:0] op, input int n, input logic [3:0] tap);
        int l;
        case (op)
            2'd0:    l = 6;
            2'd1:    l = n + 6;
            2'd2:    l = n + 5;
            default: l = n;
        endcase
        if (op != 2'd0 && tap == 4'd0) l++;
        return l;
    endfunction

    // seq: expected TMS bits in order ("" = do not check the bits).
    task automatic run_cmd(input string tag, input logic [1:0] op, input int len,
                           input logic [63:0] data, input string seq, input logic [63:0] exp_rsp);
        int L;
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_data  = data[MAX_LEN-1:0];
        n = 0;
        while (!cmd_ready && n < 200) begin
            step();
            n++;
        end
        chk({tag, ":rdy"}, 64'(cmd_ready), 64'd1);
        L = seq_len(op, len + 1, tap_m);
        step();
        cmd_valid = 1'b0;
        for (int j = 0; j < L; j++) begin
            if (seq.len() != 0) chk({tag, ":tms"}, 64'(TMS), 64'(seq.getc(j) == "1"));
            chk({tag, ":busy"}, 64'({cmd_ready, rsp_valid}), 64'd0);
            step();
        end
        chk({tag, ":vld"}, 64'(rsp_valid), 64'd1);
        chk({tag, ":rdy_lo"}, 64'(cmd_ready), 64'd0);
        chk({tag, ":data"}, 64'(rsp_data), exp_rsp);
        chk({tag, ":end"}, 64'(STATE_MIR), 64'd1);
        step();
        chk({tag, ":vld_lo"}, 64'(rsp_valid), 64'd0);
        chk({tag, ":rdy_hi"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        int          len;
        logic [63:0] data, exp;

        // Reset state
        step();
        step();
        chk("rst:tms", 64'(TMS), 64'd1);
        chk("rst:tdi", 64'(TDI), 64'd0);
        chk("rst:rdy", 64'(cmd_ready), 64'd1);
        chk("rst:vld", 64'(rsp_valid), 64'd0);
        chk("rst:data", 64'(rsp_data), 64'd0);
        chk("rst:mir", 64'(STATE_MIR), 64'd0);
        TRST = 1'b0;

        run_cmd("reset", 2'd0, 0, 64'd0, "111110", 64'd0);

        // DR scan straight out of Test_logic_reset: PRE cycle prepended.
        TRST = 1'b1;
        step();
        step();
        TRST = 1'b0;
        tdo_loop = 1'b1;
        run_cmd("dr8", 2'd2, 7, 64'hA5, "01000000000110", CAP ? 64'hA5 : 64'd0);

        tdo_loop = 1'b0;
        tdo_val  = 1'b1;
        run_cmd("ir4", 2'd1, 3, 64'h9, "1100000110", CAP ? 64'hF : 64'd0);

        run_cmd("idle10", 2'd3, 9, 64'd0, "0000000000", 64'd0);

        // Abort a 16-bit DR scan on its 3rd shift bit.
        tdo_loop  = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = 5'd15;
        cmd_data  = 32'hBEEF;
        step();
        cmd_valid = 1'b0;
        repeat (5) step();
        chk("ab:tms", 64'(TMS), 64'd0);
        chk("ab:tdi", 64'(TDI), 64'd1);
        TRST = 1'b1;
        step();
        chk("ab:vld", 64'(rsp_valid), 64'd0);
        chk("ab:mir", 64'(STATE_MIR), 64'd0);
        chk("ab:tms1", 64'(TMS), 64'd1);
        chk("ab:rdy", 64'(cmd_ready), 64'd1);
        chk("ab:tdi0", 64'(TDI), 64'd0);
        TRST = 1'b0;
        repeat (3) begin
            step();
            chk("ab:quiet", 64'({rsp_valid, cmd_ready, TMS}), 64'b011);
        end

        // TRST beats a simultaneous command.
        TRST      = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        step();
        chk("tc:rdy", 64'(cmd_ready), 64'd1);
        chk("tc:tms", 64'(TMS), 64'd1);
        TRST      = 1'b0;
        cmd_valid = 1'b0;
        step();
        chk("tc:noacc", 64'({cmd_ready, TMS}), 64'b11);

        // Random commands, back to back, with occasional resets to exercise PRE.
        tdo_loop = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c % 6 == 5) begin
                TRST = 1'b1;
                step();
                TRST = 1'b0;
            end
            op   = 2'($urandom_range(0, 3));
            len  = int'($urandom_range(0, MAX_LEN - 1));
            data = {$urandom, $urandom};
            exp  = 64'd0;
            if (CAP && (op == 2'd1 || op == 2'd2))
                exp = data & ((64'd1 << (len + 1)) - 64'd1);
            run_cmd("rnd", op, len, data, "", exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tap_sequencer.md
# tap_sequencer

Command-driven JTAG master that generates TMS/TDI sequences for the `tap_controller` FSM, sharing one TCLK and TRST with it. It accepts scan, reset and idle commands from a host-side requester and walks the TAP through the standard 16-state graph. It shifts up to MAX_LEN bits per scan and returns captured TDO bits. It keeps a cycle-exact mirror of the TAP state so the host never has to track the TAP itself.

## Interface
- MAX_LEN, 32: maximum scan length in bits (2..64).
- LEN_W, $clog2(MAX_LEN): width of cmd_len.
- TCLK  in  1  clock; all logic on posedge.
- TRST  in  1  synchronous active-high reset, shared with `tap_controller`.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  0 = RESET, 1 = IR_SCAN, 2 = DR_SCAN, 3 = IDLE.
- cmd_len  in  LEN_W  bit count minus 1 (scans), or idle cycles minus 1.
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- TMS  out  1  registered TMS to the TAP.
- TDI  out  1  registered TDI.
- TDO  in  1  serial data from the scan chain.
- rsp_valid  out  1  one-cycle pulse at command completion.
- rsp_data  out  MAX_LEN  captured TDO, bit i = i-th shifted bit, right-aligned, upper bits 0.
- STATE_MIR  out  4  mirrored TAP state, same encoding as `tap_controller` (0 = Test_logic_reset … 15 = Update_IR).

## Operation
- Control FSM states: IDLE, PRE (Test_logic_reset → Run_test_idle), HEAD, SHIFT, TAIL, DONE.
- cmd_ready = 1 only in IDLE. A command is accepted on a posedge with cmd_valid & cmd_ready; op, len and data are latched.
- TMS sequences per op, one bit per cycle:
  - RESET: 1,1,1,1,1,0. Ends in Run_test_idle. Total 6 cycles.
  - IR_SCAN: HEAD 1,1,0,0 (Select_DR, Select_IR, Capture_IR, Shift_IR). SHIFT emits N bits with TMS = 0, except TMS = 1 on the last bit (→ Exit1_IR). TAIL 1,0 (Update_IR, Run_test_idle). Total N+6.
  - DR_SCAN: HEAD 1,0,0. SHIFT as above. TAIL 1,0. Total N+5.
  - IDLE: N cycles of TMS = 0 in Run_test_idle.
- If STATE_MIR = Test_logic_reset when a scan or IDLE command is accepted, one PRE cycle with TMS = 0 is prepended.
- TDI carries cmd_data[i] during SHIFT bit i and is 0 otherwise.
- STATE_MIR applies the `tap_controller` next-state function to TMS on every posedge. It therefore always equals the TAP's STATE.
- N = cmd_len+1. Values of cmd_len ≥ MAX_LEN are clamped to MAX_LEN-1.
- TDO is sampled on each posedge where TMS for a SHIFT bit is consumed (TAP in Shift_xR). The sample is written into rsp_data[i].
- DONE: rsp_valid = 1 for one cycle, rsp_data valid and held until the next accept. The FSM returns to IDLE on the next edge.
- A command offered during DONE is not accepted, because cmd_ready is 0.

## Timing
- Reset values: TMS = 1, TDI = 0, cmd_ready = 1, rsp_valid = 0, rsp_data = 0, STATE_MIR = 0, FSM = IDLE.
- Accept at edge k: the first TMS bit is visible after edge k and consumed by the TAP at edge k+1.
- For a sequence of L TMS bits, the last bit is consumed at edge k+L. rsp_valid is high after edge k+L. cmd_ready returns after edge k+L+1.
- Back-to-back throughput: one command per L+2 cycles.
- In IDLE, TMS = 0 if STATE_MIR = Run_test_idle, else TMS = 1, keeping the TAP parked.
- TRST mid-command aborts it with no rsp_valid. All outputs take reset values on the next edge, and STATE_MIR = 0, matching the TAP.
- TRST and cmd_valid on the same edge: TRST wins and the command is not accepted.

## Configuration
- TAP_SEQ_TDO_CAPTURE_EN defined: TDO is captured as above.
- TAP_SEQ_TDO_CAPTURE_EN undefined: no capture register is built, rsp_data is tied to 0, and the TDO input is unused. rsp_valid timing is unchanged.

## Test plan
- TRST for 2 cycles, then RESET command → TMS 1,1,1,1,1,0. STATE_MIR ends at 1; rsp_valid is high 6 cycles after accept.
- From reset, DR_SCAN cmd_len = 7, cmd_data = 0xA5, TDO looped from TDI → one PRE cycle, STATE_MIR passes 2,3,4×8,5,8,1. Expect rsp_data = 0xA5, total 14 cycles.
- IR_SCAN cmd_len = 3, data = 0x9, TDO held 1 → STATE_MIR passes 2,9,10,11×4,12,15,1. Expect rsp_data = 0xF.
- IDLE cmd_len = 9 → 10 cycles of TMS = 0 and STATE_MIR stays 1. cmd_ready is low throughout and high 2 cycles after the last.
- TRST asserted during the 3rd SHIFT bit of a 16-bit DR scan → no rsp_valid, STATE_MIR = 0, TMS = 1, cmd_ready = 1 next cycle.
- Compare STATE_MIR against an instantiated `tap_controller` STATE on every cycle over 1000 random commands → no mismatch.
